// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : grants one of NCORES cores access to a fixed-latency data
//               memory and returns a one-cycle dacq with broadcast read data.
// Optional    : ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
   parameter int NCORES  = 4,
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int MEM_LAT = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [NCORES-1:0]          req,
   input  logic [NCORES-1:0]          wen,
   input  logic [NCORES*AW-1:0]       addr,
   input  logic [NCORES*DW-1:0]       wdata,
   output logic [NCORES-1:0]          dacq,
   output logic [DW-1:0]              rdata,
   output logic [AW-1:0]              mem_addr,
   output logic [DW-1:0]              mem_wdata,
   output logic                       mem_we,
   input  logic [DW-1:0]              mem_rdata,
   output logic [$clog2(NCORES)-1:0]  grant_id,
   output logic                       busy
);

   localparam int IDW = $clog2(NCORES);
   localparam int CW  = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   cnt;
   logic [IDW-1:0]  winner;

`ifdef ARB_FIXED_PRIO_EN
   // Descending scan so the lowest requesting index is the final assignment.
   always_comb begin
      winner = '0;
      for (int i = NCORES - 1; i >= 0; i--) begin
         if (req[i]) winner = IDW'(i);
      end
   end
`else
   logic [IDW-1:0]  last;
   logic [IDW-1:0]  idx;

   // Scan offsets from farthest to nearest so the first set bit after last wins.
   always_comb begin
      winner = '0;
      idx    = '0;
      for (int i = NCORES; i >= 1; i--) begin
         idx = IDW'((int'(last) + i) % NCORES);
         if (req[idx]) winner = idx;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last <= IDW'(NCORES - 1);
      end else if (state_q == IDLE && |req) begin
         last <= winner;
      end
   end
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req) state_d = ACCESS;
         ACCESS:  if (cnt == '0) state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt       <= '0;
         dacq      <= '0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         grant_id  <= '0;
      end else begin
         // Write strobe and acknowledge are single-cycle pulses.
         mem_we <= 1'b0;
         dacq   <= '0;
         case (state_q)
            IDLE: begin
               if (|req) begin
                  mem_addr  <= addr[int'(winner)*AW +: AW];
                  mem_wdata <= wdata[int'(winner)*DW +: DW];
                  mem_we    <= wen[winner];
                  grant_id  <= winner;
                  cnt       <= CW'(MEM_LAT - 1);
               end
            end
            ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rdata          <= mem_rdata;
                  dacq[grant_id] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter : directed scoreboard bench for mem_arbiter (NCORES=4, MEM_LAT=2).
module tb_mem_arbiter;

   localparam int NCORES  = 4;
   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int MEM_LAT = 2;
   localparam int GAP     = MEM_LAT + 2;

   logic                 CLK = 1'b0;
   logic                 RST = 1'b1;
   logic [NCORES-1:0]    req = '0;
   logic [NCORES-1:0]    wen = '0;
   logic [NCORES*AW-1:0] addr = '0;
   logic [NCORES*DW-1:0] wdata = '0;
   logic [NCORES-1:0]    dacq;
   logic [DW-1:0]        rdata;
   logic [AW-1:0]        mem_addr;
   logic [DW-1:0]        mem_wdata;
   logic                 mem_we;
   logic [DW-1:0]        mem_rdata;
   logic [1:0]           grant_id;
   logic                 busy;

   mem_arbiter #(.NCORES(NCORES), .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
      .CLK(CLK), .RST(RST), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
      .dacq(dacq), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata), .grant_id(grant_id), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Synchronous RAM: one output register, so data is ready MEM_LAT edges after the address.
   logic [DW-1:0] mem [256];
   logic [DW-1:0] mem_q = '0;
   always @(posedge CLK) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_q <= mem[mem_addr];
   end
   assign mem_rdata = mem_q;

   typedef struct {
      int         core;
      logic [7:0] data;
      bit         chk_rd;
      int         gap;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_ack_cyc = 0;

   always @(posedge CLK) cyc++;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge CLK) begin
      if (!RST && dacq != '0) begin
         if (sb.size() == 0) begin
            check("unexpected_dacq", 32'(dacq), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("dacq_onehot", 32'(dacq), 32'd1 << mon_e.core);
            check("ack_grant_id", 32'(grant_id), 32'(mon_e.core));
            if (mon_e.chk_rd) check("rdata", 32'(rdata), 32'(mon_e.data));
            if (mon_e.gap > 0) check("ack_spacing", 32'(cyc - last_ack_cyc), 32'(mon_e.gap));
         end
         last_ack_cyc = cyc;
      end
   end

   task automatic check_all_zero(string tag);
      check({tag, "_dacq"},      32'(dacq),      32'd0);
      check({tag, "_rdata"},     32'(rdata),     32'd0);
      check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, "_mem_we"},    32'(mem_we),    32'd0);
      check({tag, "_grant_id"},  32'(grant_id),  32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
   endtask

   // One isolated access by a single core; checks grant-cycle outputs and ack latency.
   task automatic do_access(int core, bit wr, logic [7:0] a, logic [7:0] d,
                            logic [7:0] exp_rd, bit perturb);
      int waits;
      @(negedge CLK);
      req[core] = 1'b1;
      wen[core] = wr;
      addr[core*AW +: AW]  = a;
      wdata[core*DW +: DW] = d;
      sb.push_back('{core, exp_rd, !wr, 0});
      @(negedge CLK);
      check("grant_mem_addr", 32'(mem_addr), 32'(a));
      check("grant_mem_we",   32'(mem_we),   32'(wr));
      if (wr) check("grant_mem_wdata", 32'(mem_wdata), 32'(d));
      check("grant_busy", 32'(busy), 32'd1);
      req[core] = 1'b0;
      if (perturb) begin
         addr[core*AW +: AW]  = ~a;
         wdata[core*DW +: DW] = ~d;
         wen[core]            = ~wr;
      end
      waits = 1;
      while (dacq == '0 && waits < 20) begin
         @(negedge CLK);
         if (dacq == '0) begin
            check("hold_mem_addr", 32'(mem_addr), 32'(a));
            check("hold_mem_we",   32'(mem_we),   32'd0);
            check("hold_busy",     32'(busy),     32'd1);
            waits++;
         end
      end
      check("ack_latency", 32'(waits), 32'(MEM_LAT));
      check("ack_busy", 32'(busy), 32'd1);
      @(negedge CLK);
      check("post_ack_dacq", 32'(dacq), 32'd0);
      check("post_ack_busy", 32'(busy), 32'd0);
   endtask

   task automatic wait_acks(int n, bit drop);
      int got = 0;
      int cb  = 0;
      while (got < n && cb < 100) begin
         @(negedge CLK);
         cb++;
         if (dacq != '0) begin
            got++;
            if (drop) req = req & ~dacq;
         end
      end
      check("acks_seen", 32'(got), 32'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 8'h5A;
      mem[8'h30] = 8'h77;
      mem[8'h40] = 8'h11;
      mem[8'h41] = 8'h22;
      mem[8'h42] = 8'h33;
      mem[8'h43] = 8'h44;

      #1;
      check_all_zero("reset");
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;

      // Single read by core 2, then write/readback by core 0, then mid-access perturbation.
      do_access(2, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b0);
      do_access(0, 1'b1, 8'h20, 8'hC3, 8'h00, 1'b0);
      do_access(0, 1'b0, 8'h20, 8'h00, 8'hC3, 1'b0);
      do_access(3, 1'b0, 8'h30, 8'h00, 8'h77, 1'b1);
      wen = '0;

      // All four cores request together after a fresh reset.
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      addr = {8'h43, 8'h42, 8'h41, 8'h40};
      sb.push_back('{0, 8'h11, 1'b1, 0});
      sb.push_back('{1, 8'h22, 1'b1, GAP});
      sb.push_back('{2, 8'h33, 1'b1, GAP});
      sb.push_back('{3, 8'h44, 1'b1, GAP});
      req = 4'b1111;
      wait_acks(4, 1'b1);
      check("all_req_dropped", 32'(req), 32'd0);

      // Cores 1 and 3 hold requests continuously.
`ifdef ARB_FIXED_PRIO_EN
      sb.push_back('{1, 8'h22, 1'b1, 0});
      sb.push_back('{1, 8'h22, 1'b1, GAP});
      sb.push_back('{1, 8'h22, 1'b1, GAP});
      sb.push_back('{1, 8'h22, 1'b1, GAP});
`else
      sb.push_back('{1, 8'h22, 1'b1, 0});
      sb.push_back('{3, 8'h44, 1'b1, GAP});
      sb.push_back('{1, 8'h22, 1'b1, GAP});
      sb.push_back('{3, 8'h44, 1'b1, GAP});
`endif
      @(negedge CLK);
      req = 4'b1010;
      wait_acks(4, 1'b0);
      req = '0;

      // Reset during an ACCESS of a core 1 read; then cores 1 and 2 compete.
      @(negedge CLK);
      @(negedge CLK);
      req = 4'b0010;
      @(negedge CLK);
      check("pre_reset_mem_addr", 32'(mem_addr), 32'h41);
      check("pre_reset_busy", 32'(busy), 32'd1);
      RST = 1'b1;
      #1;
      check_all_zero("async_reset");
      req = 4'b0110;
      sb.push_back('{1, 8'h22, 1'b1, 0});
      sb.push_back('{2, 8'h33, 1'b1, GAP});
      @(negedge CLK);
      check("in_reset_dacq", 32'(dacq), 32'd0);
      RST = 1'b0;
      wait_acks(2, 1'b1);

      repeat (5) @(negedge CLK);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
